calc_entry_controller: RTL and testbench
========================================

# calc_entry_controller

Consumes 5-bit key codes from the keypad scanner via a valid/ready handshake and turns them into calculator operations. Assembles hex operands digit by digit, tracks the pending operator, and issues operand/opcode transactions to the downstream ALU. Supports chained operations and holds a display value plus an error flag for the display driver.

## Interface
- `WIDTH`, default 16: operand/result width in bits. Must be a multiple of 4 and at least 8.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `i_data` input 5: key code.
  - `0_dddd` is hex digit d.
  - `10000` is +, `10001` is −, `10010` is ×, `10011` is ÷, `10100` is =, `10101` is AC.
  - `10110`, `10111` and `11xxx` are reserved.
- `i_valid` input 1: key code valid.
- `o_ready` input-side handshake output 1: key accepted when `i_valid && o_ready`.
- `o_alu_a` output WIDTH: operand A.
- `o_alu_b` output WIDTH: operand B.
- `o_alu_op` output 2: opcode, 00 add, 01 sub, 10 mul, 11 div.
- `o_alu_valid` output 1: ALU request valid.
- `i_alu_ready` input 1: ALU accepts request.
- `i_res` input WIDTH: ALU result.
- `i_res_err` input 1: ALU error (div by zero, overflow).
- `i_res_valid` input 1: result valid, single-cycle pulse.
- `o_display` output WIDTH: value to display.
- `o_error` output 1: sticky error flag.

## Operation
- Registers:
  - `a`, `b` (WIDTH): operands.
  - `op` (2): current operator.
  - `next_op` (2) and `chain` (1): operator queued behind a computation.
  - `err`, `state`.
- State ENTER_A:
  - Digit: `a <= {a[WIDTH-5:0], d}`, but only if `a[WIDTH-1:WIDTH-4]==0`; otherwise the digit is dropped.
  - +−×÷: `op <=` key, go to OP_PENDING.
  - =: no effect.
- State OP_PENDING:
  - Digit: `b <= d`, go to ENTER_B.
  - +−×÷: replaces `op`.
  - =: no effect.
- State ENTER_B:
  - Digit: shifts into `b` with the same overflow rule as `a`.
  - =: `chain <= 0`, go to CALC.
  - +−×÷: `next_op <=` key, `chain <= 1`, go to CALC.
- State CALC:
  - `o_alu_valid=1` with `a`, `b`, `op` held stable.
  - On `i_alu_ready`, go to WAIT_RES.
- State WAIT_RES, on `i_res_valid`:
  - `a <= i_res`, `err <= i_res_err`.
  - If `chain`: `op <= next_op`, `chain <= 0`, go to OP_PENDING.
  - Else go to RESULT.
- State RESULT:
  - Digit: `a <= d`, go to ENTER_A (starts a new entry).
  - +−×÷: `op <=` key, go to OP_PENDING.
  - =: no effect.
- AC, in any accepting state: `a=b=0`, `op=00`, `chain=0`, `err=0`, go to ENTER_A.
- While `err=1`, every accepted key other than AC is consumed and discarded.
- Reserved codes are consumed with no effect.
- `o_display = (state==ENTER_B) ? b : a`.
- `o_error = err`.

## Timing
- Reset values:
  - state ENTER_A, `a=b=0`, `op=next_op=00`, `chain=0`, `err=0`.
  - Outputs: `o_alu_valid=0`, `o_display=0`, `o_error=0`, `o_ready=1`.
- `o_ready` is decoded from `state` only, with no dependence on `i_valid`:
  - 1 in ENTER_A, OP_PENDING, ENTER_B, RESULT.
  - 0 in CALC, WAIT_RES.
- Key latency: a key accepted at edge N updates registers and `o_display` from cycle N+1.
- Launch: a terminating key accepted at edge N gives `o_alu_valid=1` from cycle N+1.
  - A transfer at edge M (`o_alu_valid && i_alu_ready`) drops `o_alu_valid` from M+1.
  - With `i_alu_ready` tied high, the request lasts exactly one cycle.
- `o_alu_a`, `o_alu_b`, `o_alu_op` must not change while `o_alu_valid=1 && !i_alu_ready`.
- `i_res_valid` is sampled only in WAIT_RES and ignored in every other state.
- A result received at edge R gives updated `o_display`/`o_error` and `o_ready=1` from cycle R+1.
- `rst` asserted mid-transaction (CALC/WAIT_RES) returns to reset values next edge. A later stray `i_res_valid` is ignored.
- Upstream holds `i_valid`/`i_data` while `o_ready=0`; no key is lost or duplicated.

## Test plan
- **Basic add:** reset, keys 1,2,+,3,= → request `a=0x0012`, `b=0x0003`, `op=00`. Return `i_res=0x0015` → `o_display=0x0015`, `o_ready=1`, RESULT.
- **Digit overflow:** keys 1,2,3,4,5 (WIDTH=16) → `o_display=0x1234`. The fifth key is accepted (`o_ready` stays 1) and dropped.
- **Chaining:**
  - Keys 2,×,3,+ → request `a=2`, `b=3`, `op=10`. Result 6 → OP_PENDING, `op=00`, display 6.
  - Then keys 4,= → request `a=6`, `b=4`, `op=00`.
- **Operator replace and new entry:**
  - Keys 7,+,−,2,= → `op=01`.
  - Key 9 after the result → `o_display=0x0009`, ENTER_A.
- **Error and backpressure:**
  - Keys 8,÷,0,= with `i_alu_ready` low for 3 cycles → `o_alu_valid` and operands held stable 3 cycles, `o_ready=0`.
  - Return `i_res_err=1` → `o_error=1`. Key 5 is consumed without effect. AC → `o_error=0`, `o_display=0`.
- **Reset and stray inputs:**
  - `rst` pulsed during WAIT_RES, then `i_res_valid` pulsed → all outputs at reset values, display stays 0.
  - Key code `10110` → no effect.

Source files
------------

// File: rtl/calc_entry_controller.sv
// calc_entry_controller
// Turns keypad key codes into calculator operations: assembles hex operands
// digit by digit, tracks the pending operator (including one operator queued
// behind a running computation), issues operand/opcode requests to the ALU
// and keeps the value and error flag shown by the display driver.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   i_data[4:0]  key code: 0_dddd hex digit, 10000 +, 10001 -, 10010 x,
//                10011 /, 10100 =, 10101 AC, everything else reserved
//   i_valid      key code valid
//   o_ready      key accepted when i_valid && o_ready (decoded from state only)
//   o_alu_a/b    ALU operands, held stable while a request is pending
//   o_alu_op     ALU opcode: 00 add, 01 sub, 10 mul, 11 div
//   o_alu_valid  ALU request valid
//   i_alu_ready  ALU accepts the request
//   i_res        ALU result
//   i_res_err    ALU error (divide by zero, overflow)
//   i_res_valid  single-cycle result strobe, only looked at while waiting
//   o_display    value to display (operand B while it is being typed, else A)
//   o_error      sticky error flag, cleared only by AC or reset
module calc_entry_controller #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [1:0]       o_alu_op,
  output logic             o_alu_valid,
  input  logic             i_alu_ready,
  input  logic [WIDTH-1:0] i_res,
  input  logic             i_res_err,
  input  logic             i_res_valid,
  output logic [WIDTH-1:0] o_display,
  output logic             o_error
);

  typedef enum logic [2:0] {
    ST_ENTER_A    = 3'd0,
    ST_OP_PENDING = 3'd1,
    ST_ENTER_B    = 3'd2,
    ST_CALC       = 3'd3,
    ST_WAIT_RES   = 3'd4,
    ST_RESULT     = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [1:0]       op_r, op_s;
  logic [1:0]       next_op_r, next_op_s;
  logic             chain_r, chain_s;
  logic             err_r, err_s;

  logic             ready_s;
  logic             key_accept_s;
  logic             key_digit_s;
  logic             key_op_s;
  logic             key_eq_s;
  logic             key_ac_s;
  logic             key_reserved_s;
  logic [3:0]       digit_s;
  logic [WIDTH-1:0] a_shift_s;
  logic [WIDTH-1:0] b_shift_s;
  logic [WIDTH-1:0] digit_ext_s;

  // Key classification and digit-shift candidates.
  always_comb begin
    key_digit_s    = ~i_data[4];
    key_op_s       = (i_data[4:2] == 3'b100);
    key_eq_s       = (i_data == 5'b10100);
    key_ac_s       = (i_data == 5'b10101);
    key_reserved_s = i_data[4] & ~key_op_s & ~key_eq_s & ~key_ac_s;
    digit_s        = i_data[3:0];
    digit_ext_s    = {{(WIDTH-4){1'b0}}, digit_s};
    // A digit only shifts in while the top nibble is still empty, so no
    // entered digit is ever silently pushed out of the operand.
    if (a_r[WIDTH-1 -: 4] == 4'h0) begin
      a_shift_s = {a_r[WIDTH-5:0], digit_s};
    end else begin
      a_shift_s = a_r;
    end
    if (b_r[WIDTH-1 -: 4] == 4'h0) begin
      b_shift_s = {b_r[WIDTH-5:0], digit_s};
    end else begin
      b_shift_s = b_r;
    end
  end

  // Ready is a pure function of the state so upstream sees no combinational path.
  always_comb begin
    case (state_r)
      ST_ENTER_A, ST_OP_PENDING, ST_ENTER_B, ST_RESULT: ready_s = 1'b1;
      default:                                          ready_s = 1'b0;
    endcase
    key_accept_s = i_valid & ready_s;
  end

  // Next-state and next-register computation.
  always_comb begin
    state_s   = state_r;
    a_s       = a_r;
    b_s       = b_r;
    op_s      = op_r;
    next_op_s = next_op_r;
    chain_s   = chain_r;
    err_s     = err_r;
    case (state_r)
      ST_CALC: begin
        if (i_alu_ready) begin
          state_s = ST_WAIT_RES;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_WAIT_RES: begin
        if (i_res_valid) begin
          a_s   = i_res;
          err_s = i_res_err;
          if (chain_r) begin
            op_s    = next_op_r;
            chain_s = 1'b0;
            state_s = ST_OP_PENDING;
          end else begin
            state_s = ST_RESULT;
          end
        end else begin
          state_s = ST_WAIT_RES;
        end
      end
      ST_ENTER_A, ST_OP_PENDING, ST_ENTER_B, ST_RESULT: begin
        if (!key_accept_s) begin
          state_s = state_r;
        end else if (key_ac_s) begin
          a_s     = '0;
          b_s     = '0;
          op_s    = 2'b00;
          chain_s = 1'b0;
          err_s   = 1'b0;
          state_s = ST_ENTER_A;
        end else if (err_r || key_reserved_s) begin
          // Key is consumed and has no effect.
          state_s = state_r;
        end else begin
          case (state_r)
            ST_ENTER_A: begin
              if (key_digit_s) begin
                a_s = a_shift_s;
              end else if (key_op_s) begin
                op_s    = i_data[1:0];
                state_s = ST_OP_PENDING;
              end else begin
                state_s = ST_ENTER_A;
              end
            end
            ST_OP_PENDING: begin
              if (key_digit_s) begin
                b_s     = digit_ext_s;
                state_s = ST_ENTER_B;
              end else if (key_op_s) begin
                op_s = i_data[1:0];
              end else begin
                state_s = ST_OP_PENDING;
              end
            end
            ST_ENTER_B: begin
              if (key_digit_s) begin
                b_s = b_shift_s;
              end else if (key_op_s) begin
                // Operator typed after B: compute now, apply it to the result.
                next_op_s = i_data[1:0];
                chain_s   = 1'b1;
                state_s   = ST_CALC;
              end else begin
                chain_s = 1'b0;
                state_s = ST_CALC;
              end
            end
            ST_RESULT: begin
              if (key_digit_s) begin
                a_s     = digit_ext_s;
                state_s = ST_ENTER_A;
              end else if (key_op_s) begin
                op_s    = i_data[1:0];
                state_s = ST_OP_PENDING;
              end else begin
                state_s = ST_RESULT;
              end
            end
            default: begin
              state_s = ST_ENTER_A;
            end
          endcase
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean entry state.
        a_s     = '0;
        b_s     = '0;
        op_s    = 2'b00;
        chain_s = 1'b0;
        err_s   = 1'b0;
        state_s = ST_ENTER_A;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_ENTER_A;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= 2'b00;
      next_op_r <= 2'b00;
      chain_r   <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      a_r       <= a_s;
      b_r       <= b_s;
      op_r      <= op_s;
      next_op_r <= next_op_s;
      chain_r   <= chain_s;
      err_r     <= err_s;
    end
  end

  // Outputs are decoded straight from registers; operands cannot move in CALC.
  always_comb begin
    o_ready     = ready_s;
    o_alu_a     = a_r;
    o_alu_b     = b_r;
    o_alu_op    = op_r;
    o_alu_valid = (state_r == ST_CALC);
    o_error     = err_r;
    if (state_r == ST_ENTER_B) begin
      o_display = b_r;
    end else begin
      o_display = a_r;
    end
  end

endmodule

// File: tb/tb_calc_entry_controller.sv
// Testbench for calc_entry_controller: directed key sequences; expected ALU
// requests go into a queue that a separate monitor checks on every transfer.
module tb_calc_entry_controller;
  localparam int W = 16;

  localparam logic [4:0] K_ADD = 5'b10000;
  localparam logic [4:0] K_SUB = 5'b10001;
  localparam logic [4:0] K_MUL = 5'b10010;
  localparam logic [4:0] K_DIV = 5'b10011;
  localparam logic [4:0] K_EQ  = 5'b10100;
  localparam logic [4:0] K_AC  = 5'b10101;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
  } req_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   i_data;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] o_alu_a;
  logic [W-1:0] o_alu_b;
  logic [1:0]   o_alu_op;
  logic         o_alu_valid;
  logic         i_alu_ready;
  logic [W-1:0] i_res;
  logic         i_res_err;
  logic         i_res_valid;
  logic [W-1:0] o_display;
  logic         o_error;

  int   errors = 0;
  int   checks = 0;
  req_t exp_q[$];

  calc_entry_controller #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_alu_a    (o_alu_a),
    .o_alu_b    (o_alu_b),
    .o_alu_op   (o_alu_op),
    .o_alu_valid(o_alu_valid),
    .i_alu_ready(i_alu_ready),
    .i_res      (i_res),
    .i_res_err  (i_res_err),
    .i_res_valid(i_res_valid),
    .o_display  (o_display),
    .o_error    (o_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] dg(input logic [3:0] d);
    return {1'b0, d};
  endfunction

  task automatic expect_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    req_t r;
    r.a  = a;
    r.b  = b;
    r.op = op;
    exp_q.push_back(r);
  endtask

  // Present a key and hold it until the DUT accepts it.
  task automatic key(input logic [4:0] k);
    int n;
    n       = 0;
    i_data  = k;
    i_valid = 1'b1;
    while (o_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) timeout("key_accept");
    step();
    i_valid = 1'b0;
  endtask

  // Wait until the DUT is waiting for a result, then deliver one.
  task automatic result(input logic [W-1:0] r, input logic e);
    int n;
    n = 0;
    while (!(o_ready === 1'b0 && o_alu_valid === 1'b0) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) timeout("wait_res");
    i_res       = r;
    i_res_err   = e;
    i_res_valid = 1'b1;
    step();
    i_res_valid = 1'b0;
  endtask

  // Monitor: every ALU transfer must match the oldest expected request.
  always @(negedge clk) begin
    if (!rst && o_alu_valid === 1'b1 && i_alu_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("alu_req_unexpected", {30'd0, o_alu_a, o_alu_b, o_alu_op}, 64'd0);
      end else begin
        req_t e;
        e = exp_q.pop_front();
        check("alu_req", {30'd0, o_alu_a, o_alu_b, o_alu_op}, {30'd0, e.a, e.b, e.op});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    i_data      = 5'd0;
    i_valid     = 1'b0;
    i_alu_ready = 1'b1;
    i_res       = '0;
    i_res_err   = 1'b0;
    i_res_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_display", o_display, 0);
    check("rst_error", o_error, 0);
    check("rst_ready", o_ready, 1);
    check("rst_alu_valid", o_alu_valid, 0);

    // Basic add: 12 + 3
    key(dg(4'h1));
    key(dg(4'h2));
    check("add_disp_a", o_display, 16'h0012);
    key(K_ADD);
    key(dg(4'h3));
    check("add_disp_b", o_display, 16'h0003);
    expect_req(16'h0012, 16'h0003, 2'b00);
    key(K_EQ);
    check("add_valid_n1", o_alu_valid, 1);
    step();
    check("add_valid_one_cycle", o_alu_valid, 0);
    check("add_ready_wait", o_ready, 0);
    result(16'h0015, 1'b0);
    check("add_result", o_display, 16'h0015);
    check("add_ready_after", o_ready, 1);
    check("add_error", o_error, 0);

    // Digit overflow: fifth digit dropped
    key(dg(4'h1));
    check("new_entry_from_result", o_display, 16'h0001);
    key(dg(4'h2));
    key(dg(4'h3));
    key(dg(4'h4));
    check("ovf_ready_before_5th", o_ready, 1);
    key(dg(4'h5));
    check("ovf_display", o_display, 16'h1234);
    check("ovf_ready_after", o_ready, 1);
    key(K_AC);
    check("ac_display", o_display, 16'h0000);

    // Chaining: 2 x 3 + 4 =
    key(dg(4'h2));
    key(K_MUL);
    key(dg(4'h3));
    expect_req(16'h0002, 16'h0003, 2'b10);
    key(K_ADD);
    result(16'h0006, 1'b0);
    check("chain_display", o_display, 16'h0006);
    check("chain_ready", o_ready, 1);
    key(dg(4'h4));
    check("chain_disp_b", o_display, 16'h0004);
    expect_req(16'h0006, 16'h0004, 2'b00);
    key(K_EQ);
    result(16'h000A, 1'b0);
    check("chain_result", o_display, 16'h000A);

    // Operator replace: 7 + - 2 =, then new entry 9, 1
    key(dg(4'h7));
    check("repl_disp_a", o_display, 16'h0007);
    key(K_ADD);
    key(K_SUB);
    key(dg(4'h2));
    expect_req(16'h0007, 16'h0002, 2'b01);
    key(K_EQ);
    result(16'h0005, 1'b0);
    check("repl_result", o_display, 16'h0005);
    key(dg(4'h9));
    check("new_entry_9", o_display, 16'h0009);
    key(dg(4'h1));
    check("new_entry_91", o_display, 16'h0091);

    // Error with ALU backpressure: 8 / 0 =
    key(K_AC);
    i_alu_ready = 1'b0;
    key(dg(4'h8));
    key(K_DIV);
    key(dg(4'h0));
    expect_req(16'h0008, 16'h0000, 2'b11);
    key(K_EQ);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", o_alu_valid, 1);
      check("bp_ready", o_ready, 0);
      check("bp_hold", {30'd0, o_alu_a, o_alu_b, o_alu_op}, {30'd0, 16'h0008, 16'h0000, 2'b11});
      step();
    end
    i_alu_ready = 1'b1;
    step();
    check("bp_valid_drop", o_alu_valid, 0);
    result(16'hFFFF, 1'b1);
    check("err_flag", o_error, 1);
    check("err_display", o_display, 16'hFFFF);
    key(dg(4'h5));
    check("err_key_ignored", o_display, 16'hFFFF);
    check("err_still_set", o_error, 1);
    key(K_AC);
    check("err_cleared", o_error, 0);
    check("err_ac_display", o_display, 16'h0000);

    // Reset during WAIT_RES, then a stray result strobe
    key(dg(4'h3));
    key(K_ADD);
    key(dg(4'h4));
    expect_req(16'h0003, 16'h0004, 2'b00);
    key(K_EQ);
    step();
    check("wait_ready_low", o_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_ready", o_ready, 1);
    check("midrst_valid", o_alu_valid, 0);
    check("midrst_display", o_display, 0);
    i_res       = 16'h5555;
    i_res_err   = 1'b1;
    i_res_valid = 1'b1;
    step();
    i_res_valid = 1'b0;
    check("stray_display", o_display, 0);
    check("stray_error", o_error, 0);
    check("stray_ready", o_ready, 1);

    // Reserved codes have no effect
    key(5'b10110);
    check("rsv_display", o_display, 0);
    key(dg(4'h6));
    check("rsv_then_digit", o_display, 16'h0006);
    key(5'b11000);
    check("rsv2_display", o_display, 16'h0006);
    key(K_EQ);
    check("eq_in_enter_a", o_alu_valid, 0);
    step();
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
